// File: rtl/vseq_pkg.sv
// Shared types and width helpers for the vector sequencer.
// The state encoding is also used by the sequencer's FSM registers.
package vseq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } vseq_state_e;

  localparam int VSEQ_DEF_NUM_IN  = 3;
  localparam int VSEQ_DEF_NUM_OUT = 1;
  localparam int VSEQ_DEF_DEPTH   = 16;

  function automatic int vec_width(input int num_in, input int num_out);
    return num_in + num_out;
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Counters must reach DEPTH itself, hence depth+1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vseq_mem.sv
// Vector store: DEPTH x VW register array, one synchronous write port, one async read port.
// Read data follows the address in the same cycle; no reset, contents survive a sequencer reset.
module vseq_mem #(
  parameter int DEPTH = 16,
  parameter int VW    = 4,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [VW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [VW-1:0] rdata
);

  logic [VW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vector_sequencer.sv
// Applies stored {inputs, expected} words to a combinational DUT, SETTLE+2 cycles per vector; start/ld_en ignored while busy.
// Define VSEQ_STOP_ON_FAIL_EN to end a run at the first mismatching vector.
module vector_sequencer
  import vseq_pkg::*;
#(
  parameter  int NUM_IN  = VSEQ_DEF_NUM_IN,
  parameter  int NUM_OUT = VSEQ_DEF_NUM_OUT,
  parameter  int DEPTH   = VSEQ_DEF_DEPTH,
  parameter  int SETTLE  = 1,
  localparam int VW      = vec_width(NUM_IN, NUM_OUT),
  localparam int AW      = addr_width(DEPTH),
  localparam int CW      = cnt_width(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld_en,
  input  logic [AW-1:0]      ld_addr,
  input  logic [VW-1:0]      ld_data,
  input  logic [CW-1:0]      num_vec,
  input  logic               start,
  output logic [NUM_IN-1:0]  dut_in,
  input  logic [NUM_OUT-1:0] dut_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CW-1:0]      vec_idx,
  output logic [CW-1:0]      err_cnt,
  output logic [VW-1:0]      fail_vec,
  output logic [NUM_OUT-1:0] fail_got
);

`ifdef VSEQ_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam int            SW          = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE);

  vseq_state_e   state_q, state_d;
  logic [SW-1:0] settle_q;
  logic [CW-1:0] num_lat;
  logic [VW-1:0] cur_vec;

  logic          accept;
  logic          wr_en;
  logic          mismatch;
  logic          last_vec;
  logic [AW-1:0] rd_addr;
  logic [VW-1:0] mem_rdata;
  logic [VW-1:0] rd_word;

  assign busy   = (state_q == APPLY) || (state_q == CHECK);
  assign done   = (state_q == DONE);
  assign pass   = done && (err_cnt == '0);
  assign dut_in = cur_vec[VW-1:NUM_OUT];

  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign wr_en    = ld_en && !busy;
  assign mismatch = (dut_out != cur_vec[NUM_OUT-1:0]);
  assign last_vec = ((vec_idx + CW'(1)) == num_lat);

  // Only two reads are ever needed: word 0 at start, and the following word while in CHECK.
  assign rd_addr = (state_q == CHECK) ? (vec_idx[AW-1:0] + AW'(1)) : '0;

  vseq_mem #(
    .DEPTH (DEPTH),
    .VW    (VW),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  // A load in the start cycle lands at the same edge, so forward it to the first vector.
  assign rd_word = (wr_en && (ld_addr == rd_addr)) ? ld_data : mem_rdata;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) state_d = (num_vec == '0) ? DONE : APPLY;
      end
      APPLY: begin
        if (settle_q == SETTLE_LAST) state_d = CHECK;
      end
      CHECK: begin
        if ((STOP_ON_FAIL && mismatch) || last_vec) state_d = DONE;
        else                                        state_d = APPLY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      settle_q <= '0;
      num_lat  <= '0;
      cur_vec  <= '0;
      vec_idx  <= '0;
      err_cnt  <= '0;
      fail_vec <= '0;
      fail_got <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            num_lat  <= (num_vec > CW'(DEPTH)) ? CW'(DEPTH) : num_vec;
            settle_q <= '0;
            vec_idx  <= '0;
            err_cnt  <= '0;
            fail_vec <= '0;
            fail_got <= '0;
            if (num_vec != '0) cur_vec <= rd_word;
          end
        end
        APPLY: begin
          settle_q <= (settle_q == SETTLE_LAST) ? '0 : settle_q + SW'(1);
        end
        CHECK: begin
          if (mismatch) begin
            err_cnt <= err_cnt + CW'(1);
            if (err_cnt == '0) begin
              fail_vec <= cur_vec;
              fail_got <= dut_out;
            end
          end
          // A stopped run keeps vec_idx on the failing vector.
          if (!(STOP_ON_FAIL && mismatch)) begin
            vec_idx <= vec_idx + CW'(1);
            if (!last_vec) cur_vec <= rd_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
